// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port word RAM between instruction fetch
// and load/store. One accept cycle is always followed by one response cycle.
module mem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int ADDR_W     = 30
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RSP_I = 2'd1,
    RSP_D = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant, last_grant_next;
  logic   store_pend, store_pend_next;
  logic   grant_i, grant_d;

  // On conflict, round-robin hands the bus to whichever port did not win last.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (resetn && (state == IDLE)) begin
      if (i_req_valid && d_req_valid) begin
        if (FIXED_PRIO || !last_grant) begin
          grant_d = 1'b1;
        end else begin
          grant_i = 1'b1;
        end
      end else begin
        grant_i = i_req_valid;
        grant_d = d_req_valid;
      end
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    store_pend_next = store_pend;
    i_req_ready     = 1'b0;
    d_req_ready     = 1'b0;
    i_rsp_valid     = 1'b0;
    i_rsp_data      = '0;
    d_rsp_valid     = 1'b0;
    d_rsp_data      = '0;
    ram_addr        = '0;
    ram_din         = '0;
    ram_re          = 1'b0;
    ram_we          = 1'b0;

    if (resetn) begin
      unique case (state)
        IDLE: begin
          if (grant_i) begin
            i_req_ready     = 1'b1;
            ram_addr        = i_addr;
            ram_re          = 1'b1;
            state_next      = RSP_I;
            last_grant_next = 1'b0;
          end else if (grant_d) begin
            d_req_ready     = 1'b1;
            ram_addr        = d_addr;
            ram_we          = d_we;
            ram_re          = !d_we;
            ram_din         = d_we ? d_wdata : 32'h0;
            state_next      = RSP_D;
            last_grant_next = 1'b1;
            store_pend_next = d_we;
          end
        end
        RSP_I: begin
          i_rsp_valid = 1'b1;
          i_rsp_data  = ram_dout;
          state_next  = IDLE;
        end
        RSP_D: begin
          // A store has nothing to return; its acknowledge carries zero.
          d_rsp_valid = 1'b1;
          d_rsp_data  = store_pend ? 32'h0 : ram_dout;
          state_next  = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      store_pend <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      store_pend <= store_pend_next;
    end
  end

  // Invariants of the one-accept-then-one-response protocol.
  a_one_ready : assert property (@(posedge clk) disable iff (!resetn)
    !(i_req_ready && d_req_ready));
  a_i_latency : assert property (@(posedge clk) disable iff (!resetn)
    i_req_ready |=> i_rsp_valid);
  a_d_latency : assert property (@(posedge clk) disable iff (!resetn)
    d_req_ready |=> d_rsp_valid);
  a_no_access_in_rsp : assert property (@(posedge clk) disable iff (!resetn)
    (i_rsp_valid || d_rsp_valid) |-> !(ram_re || ram_we));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance a is round-robin, instance b is
// fixed data priority; each has its own registered-read RAM model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_i_req_valid, a_i_req_ready, a_i_rsp_valid;
  logic [29:0] a_i_addr, a_d_addr, a_ram_addr;
  logic [31:0] a_i_rsp_data, a_d_wdata, a_d_rsp_data, a_ram_din, a_ram_dout;
  logic        a_d_req_valid, a_d_req_ready, a_d_we, a_d_rsp_valid, a_ram_re, a_ram_we;

  logic        b_i_req_valid, b_i_req_ready, b_i_rsp_valid;
  logic [29:0] b_i_addr, b_d_addr, b_ram_addr;
  logic [31:0] b_i_rsp_data, b_d_wdata, b_d_rsp_data, b_ram_din, b_ram_dout;
  logic        b_d_req_valid, b_d_req_ready, b_d_we, b_d_rsp_valid, b_ram_re, b_ram_we;

  mem_arbiter #(.FIXED_PRIO(1'b0), .ADDR_W(30)) dut_a (
    .clk(clk), .resetn(resetn),
    .i_req_valid(a_i_req_valid), .i_req_ready(a_i_req_ready), .i_addr(a_i_addr),
    .i_rsp_valid(a_i_rsp_valid), .i_rsp_data(a_i_rsp_data),
    .d_req_valid(a_d_req_valid), .d_req_ready(a_d_req_ready), .d_addr(a_d_addr),
    .d_we(a_d_we), .d_wdata(a_d_wdata),
    .d_rsp_valid(a_d_rsp_valid), .d_rsp_data(a_d_rsp_data),
    .ram_addr(a_ram_addr), .ram_din(a_ram_din), .ram_re(a_ram_re),
    .ram_we(a_ram_we), .ram_dout(a_ram_dout)
  );

  mem_arbiter #(.FIXED_PRIO(1'b1), .ADDR_W(30)) dut_b (
    .clk(clk), .resetn(resetn),
    .i_req_valid(b_i_req_valid), .i_req_ready(b_i_req_ready), .i_addr(b_i_addr),
    .i_rsp_valid(b_i_rsp_valid), .i_rsp_data(b_i_rsp_data),
    .d_req_valid(b_d_req_valid), .d_req_ready(b_d_req_ready), .d_addr(b_d_addr),
    .d_we(b_d_we), .d_wdata(b_d_wdata),
    .d_rsp_valid(b_d_rsp_valid), .d_rsp_data(b_d_rsp_data),
    .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_re(b_ram_re),
    .ram_we(b_ram_we), .ram_dout(b_ram_dout)
  );

  // Registered-read word RAMs, 16 words, using the low address bits.
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];

  always @(posedge clk) begin
    if (a_ram_we) mem_a[a_ram_addr[3:0]] <= a_ram_din;
    if (a_ram_re) a_ram_dout <= mem_a[a_ram_addr[3:0]];
    if (b_ram_we) mem_b[b_ram_addr[3:0]] <= b_ram_din;
    if (b_ram_re) b_ram_dout <= mem_b[b_ram_addr[3:0]];
  end

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic pushExp(input bit inst, input bit port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.at   = cyc + 1;
    if (inst) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  task automatic applyStimulus(input bit inst, input logic iv, input logic [29:0] ia,
                               input logic dv, input logic [29:0] da,
                               input logic dwe, input logic [31:0] dwd);
    if (inst) begin
      b_i_req_valid = iv; b_i_addr = ia;
      b_d_req_valid = dv; b_d_addr = da; b_d_we = dwe; b_d_wdata = dwd;
    end else begin
      a_i_req_valid = iv; a_i_addr = ia;
      a_d_req_valid = dv; a_d_addr = da; a_d_we = dwe; a_d_wdata = dwd;
    end
  endtask

  // Checks request-side outputs at the negedge, then advances to just past the next posedge.
  task automatic checkCycle(input bit inst, input logic eir, input logic edr,
                            input logic ere, input logic ewe, input logic [29:0] eaddr,
                            input logic [31:0] edin, input bit chk_addr);
    string p;
    p = inst ? "b_" : "a_";
    @(negedge clk);
    checkOutput({p, "i_req_ready"}, inst ? b_i_req_ready : a_i_req_ready, eir);
    checkOutput({p, "d_req_ready"}, inst ? b_d_req_ready : a_d_req_ready, edr);
    checkOutput({p, "ram_re"}, inst ? b_ram_re : a_ram_re, ere);
    checkOutput({p, "ram_we"}, inst ? b_ram_we : a_ram_we, ewe);
    if (chk_addr) checkOutput({p, "ram_addr"}, inst ? b_ram_addr : a_ram_addr, eaddr);
    if (ewe) checkOutput({p, "ram_din"}, inst ? b_ram_din : a_ram_din, edin);
    if (!ere && !ewe && chk_addr)
      checkOutput({p, "ram_din_idle"}, inst ? b_ram_din : a_ram_din, 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop an expectation whenever a response pulse appears.
  always @(negedge clk) begin
    exp_t e;
    if (a_i_rsp_valid || a_d_rsp_valid) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL a_unexpected_rsp: got i=%b d=%b expected none (cycle %0d)",
                 a_i_rsp_valid, a_d_rsp_valid, cyc);
      end else begin
        e = q_a.pop_front();
        checkOutput("a_rsp_both", {31'h0, a_i_rsp_valid & a_d_rsp_valid}, 32'h0);
        checkOutput("a_rsp_port", {31'h0, a_d_rsp_valid}, {31'h0, e.port});
        checkOutput("a_rsp_data", a_d_rsp_valid ? a_d_rsp_data : a_i_rsp_data, e.data);
        checkOutput("a_rsp_cycle", cyc, e.at);
      end
    end
    if (resetn === 1'b1) begin
      if (!a_i_rsp_valid) checkOutput("a_i_rsp_data_zero", a_i_rsp_data, 32'h0);
      if (!a_d_rsp_valid) checkOutput("a_d_rsp_data_zero", a_d_rsp_data, 32'h0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_i_rsp_valid || b_d_rsp_valid) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL b_unexpected_rsp: got i=%b d=%b expected none (cycle %0d)",
                 b_i_rsp_valid, b_d_rsp_valid, cyc);
      end else begin
        e = q_b.pop_front();
        checkOutput("b_rsp_both", {31'h0, b_i_rsp_valid & b_d_rsp_valid}, 32'h0);
        checkOutput("b_rsp_port", {31'h0, b_d_rsp_valid}, {31'h0, e.port});
        checkOutput("b_rsp_data", b_d_rsp_valid ? b_d_rsp_data : b_i_rsp_data, e.data);
        checkOutput("b_rsp_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[0] = 32'h00200013; mem_b[0] = 32'h00200013;
    mem_a[1] = 32'h00300093; mem_b[1] = 32'h00300093;
    mem_a[2] = 32'h12345678; mem_b[2] = 32'h12345678;
    a_ram_dout = 32'h0;
    b_ram_dout = 32'h0;

    // Reset with a pending fetch: everything forced low, nothing accepted.
    resetn = 1'b0;
    applyStimulus(0, 1'b1, 30'd7, 1'b0, 30'd0, 1'b0, 32'h0);
    applyStimulus(1, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 32'h0);
    @(posedge clk); #1;
    checkCycle(0, 0, 0, 0, 0, 30'd0, 32'h0, 1);
    checkCycle(0, 0, 0, 0, 0, 30'd0, 32'h0, 1);
    applyStimulus(0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 32'h0);
    checkCycle(0, 0, 0, 0, 0, 30'd0, 32'h0, 1);
    resetn = 1'b1;

    // Idle bus for 4 cycles.
    for (int k = 0; k < 4; k++) begin
      checkCycle(k[0], 0, 0, 0, 0, 30'd0, 32'h0, 1);
    end

    // Round-robin from reset: data, fetch, data, fetch.
    applyStimulus(0, 1'b1, 30'd0, 1'b1, 30'd2, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        pushExp(0, 1'b1, 32'h12345678);
        checkCycle(0, 0, 1, 1, 0, 30'd2, 32'h0, 1);
      end else begin
        pushExp(0, 1'b0, 32'h00200013);
        checkCycle(0, 1, 0, 1, 0, 30'd0, 32'h0, 1);
      end
      checkCycle(0, 0, 0, 0, 0, 30'd0, 32'h0, 0);
    end
    applyStimulus(0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 32'h0);
    checkCycle(0, 0, 0, 0, 0, 30'd0, 32'h0, 1);

    // Single fetch of word 0, valid held through the response cycle.
    applyStimulus(0, 1'b1, 30'd0, 1'b0, 30'd0, 1'b0, 32'h0);
    pushExp(0, 1'b0, 32'h00200013);
    checkCycle(0, 1, 0, 1, 0, 30'd0, 32'h0, 1);
    checkCycle(0, 0, 0, 0, 0, 30'd0, 32'h0, 0);
    applyStimulus(0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 32'h0);

    // Store then load of word 5.
    applyStimulus(0, 1'b0, 30'd0, 1'b1, 30'd5, 1'b1, 32'hDEADBEEF);
    pushExp(0, 1'b1, 32'h0);
    checkCycle(0, 0, 1, 0, 1, 30'd5, 32'hDEADBEEF, 1);
    applyStimulus(0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 32'h0);
    checkCycle(0, 0, 0, 0, 0, 30'd0, 32'h0, 0);
    applyStimulus(0, 1'b0, 30'd0, 1'b1, 30'd5, 1'b0, 32'h0);
    pushExp(0, 1'b1, 32'hDEADBEEF);
    checkCycle(0, 0, 1, 1, 0, 30'd5, 32'h0, 1);
    applyStimulus(0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 32'h0);
    checkCycle(0, 0, 0, 0, 0, 30'd0, 32'h0, 0);

    // Reset while in RSP_I drops the response; then fetch word 1.
    applyStimulus(0, 1'b1, 30'd1, 1'b0, 30'd0, 1'b0, 32'h0);
    checkCycle(0, 1, 0, 1, 0, 30'd1, 32'h0, 1);
    applyStimulus(0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 32'h0);
    resetn = 1'b0;
    checkCycle(0, 0, 0, 0, 0, 30'd0, 32'h0, 1);
    resetn = 1'b1;
    checkCycle(0, 0, 0, 0, 0, 30'd0, 32'h0, 1);
    applyStimulus(0, 1'b1, 30'd1, 1'b0, 30'd0, 1'b0, 32'h0);
    pushExp(0, 1'b0, 32'h00300093);
    checkCycle(0, 1, 0, 1, 0, 30'd1, 32'h0, 1);
    applyStimulus(0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 32'h0);
    checkCycle(0, 0, 0, 0, 0, 30'd0, 32'h0, 0);

    // Fixed priority: data wins every accept until it drops.
    applyStimulus(1, 1'b1, 30'd0, 1'b1, 30'd2, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      pushExp(1, 1'b1, 32'h12345678);
      checkCycle(1, 0, 1, 1, 0, 30'd2, 32'h0, 1);
      checkCycle(1, 0, 0, 0, 0, 30'd0, 32'h0, 0);
    end
    applyStimulus(1, 1'b1, 30'd0, 1'b0, 30'd0, 1'b0, 32'h0);
    pushExp(1, 1'b0, 32'h00200013);
    checkCycle(1, 1, 0, 1, 0, 30'd0, 32'h0, 1);
    applyStimulus(1, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 32'h0);
    checkCycle(1, 0, 0, 0, 0, 30'd0, 32'h0, 0);
    checkCycle(1, 0, 0, 0, 0, 30'd0, 32'h0, 1);

    // Every expected response must have been observed.
    checkOutput("a_queue_drained", q_a.size(), 32'h0);
    checkOutput("b_queue_drained", q_b.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port word RAM between the instruction-fetch port and the load/store port of the core.
- The RAM has a 30-bit word address, 32-bit data, separate re/we, and a registered read: dout updates on the clock edge after re.
- The arbiter grants one requester per transaction, drives the RAM port, and returns each response exactly one cycle after acceptance.
- Transactions are non-overlapping: one accept, then one response cycle.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between fetch and data on conflict; 1 = data port always wins.
- ADDR_W, 30, word-address width; must match the RAM address width.

Ports:
- clk  in  1  system clock, all state on posedge.
- resetn  in  1  synchronous active-low reset.
- i_req_valid  in  1  fetch request pending.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_addr  in  ADDR_W  fetch word address.
- i_rsp_valid  out  1  fetch data valid (one-cycle pulse).
- i_rsp_data  out  32  fetched word.
- d_req_valid  in  1  load/store request pending.
- d_req_ready  out  1  load/store accepted this cycle.
- d_addr  in  ADDR_W  load/store word address.
- d_we  in  1  1 = store, 0 = load.
- d_wdata  in  32  store data.
- d_rsp_valid  out  1  load data valid, or store acknowledge (one-cycle pulse).
- d_rsp_data  out  32  loaded word; 0 for store acknowledge.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  32  RAM write data.
- ram_re  out  1  RAM read enable.
- ram_we  out  1  RAM write enable.
- ram_dout  in  32  RAM registered read data.

Behaviour:
- FSM states: IDLE, RSP_I, RSP_D. Registers: state, last_grant (0 = fetch, 1 = data).
- IDLE, grant selection:
  - Only i_req_valid: grant fetch.
  - Only d_req_valid: grant data.
  - Both: if FIXED_PRIO=1, grant data. If FIXED_PRIO=0, grant the port that is not last_grant.
- IDLE, on grant:
  - The granted *_req_ready = 1, combinational in the same cycle as valid.
  - RAM driven combinationally the same cycle: ram_addr = granted address.
  - Fetch grant, or data load: ram_re = 1.
  - Data store: ram_we = 1, ram_din = d_wdata, ram_re = 0.
- IDLE, state update: next state RSP_I or RSP_D; last_grant updates to the granted port.
- IDLE with no valid: ram_re = ram_we = 0, ram_addr = 0, ram_din = 0, state holds.
- A request is accepted only when valid && ready. Requesters hold addr/data stable while valid && !ready. The arbiter never reads them after acceptance.
- RSP_I: i_rsp_valid = 1, i_rsp_data = ram_dout. Both ready outputs = 0, RAM enables = 0. Next state IDLE.
- RSP_D:
  - d_rsp_valid = 1.
  - d_rsp_data = ram_dout for a load, 0 for a store; the store flag is registered at acceptance.
  - Both ready outputs = 0, RAM enables = 0. Next state IDLE.
- Response latency is exactly 1 cycle after acceptance. Peak throughput is 1 transaction per 2 cycles. There is no response back-pressure: requesters must consume the pulse.
- *_rsp_data is 0 whenever the matching *_rsp_valid = 0.
- Reset (resetn = 0 at posedge): state <= IDLE, last_grant <= 0 (fetch), so data wins the first conflict in round-robin mode.
- While resetn = 0, all outputs are forced combinationally to 0: ready, rsp_valid, RAM enables, ram_addr, ram_din.
- Reset in RSP_* drops the pending response; no pulse is emitted.
- Reset in the accept cycle: no RAM access and no acceptance occur.
- A request deasserted before acceptance is simply not served.
- The address passes through unmodified; no wrap or masking. The RAM uses its own low bits.

Test Plan:
- RAM preloaded with 0x00200013 at word 0. i_req_valid=1, i_addr=0 in cycle T → i_req_ready=1 and ram_re=1 at T; i_rsp_valid=1 with i_rsp_data=0x00200013 at T+1; i_req_ready=0 at T+1.
- Store d_addr=5, d_wdata=0xDEADBEEF → ram_we=1 at T, d_rsp_valid=1 with data 0 at T+1. Then load d_addr=5 → d_rsp_data=0xDEADBEEF one cycle after its accept.
- FIXED_PRIO=0, both valid continuously from reset → grants alternate data, fetch, data, fetch. Accepts occur at T, T+2, T+4, T+6; responses at T+1, T+3, T+5, T+7.
- FIXED_PRIO=1, both valid for 6 cycles → data granted every accept cycle; fetch is never granted until d_req_valid drops.
- resetn=0 during RSP_I → no i_rsp_valid pulse. After release, i_req_valid=1 with i_addr=1 returns 0x00300093 (preloaded at word 1) with 1-cycle latency.
- Idle bus (no valids) for 4 cycles → ram_re = ram_we = 0, ram_addr = 0, all ready and rsp outputs 0, state stays IDLE.
